// File: rtl/dbg_if.sv
// ---------------------------------------------------------------------------
// dbg_if -- bundle of command, MCU-handshake and status signals between the
// serial debug front end / MCU and dbg_controller.
//
//   cmd, addr, in_valid   command stream from the serial decoder
//   pc, mcu_busy          MCU program counter and acknowledge/busy
//   pause .. mem_wr       single-bit MCU requests
//   mem_be                byte enables for memory requests
//   out_valid             request qualifier
//   ctrlr_busy            controller cannot accept a command
//   paused, bp_full       status flags
//   bp_hit                one-cycle pulse when a breakpoint is taken
//
// Modports: slave = the controller, master = the side that drives commands
// and the MCU handshake.
// ---------------------------------------------------------------------------
interface dbg_if #(
    parameter int ADDR_W = 32
) ();
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic              in_valid;
    logic [ADDR_W-1:0] pc;
    logic              mcu_busy;

    logic              pause;
    logic              resume;
    logic              reset;
    logic              rf_rd;
    logic              rf_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [3:0]        mem_be;
    logic              out_valid;
    logic              ctrlr_busy;
    logic              paused;
    logic              bp_full;
    logic              bp_hit;

    modport master (
        output cmd, addr, in_valid, pc, mcu_busy,
        input  pause, resume, reset, rf_rd, rf_wr, mem_rd, mem_wr, mem_be,
               out_valid, ctrlr_busy, paused, bp_full, bp_hit
    );

    modport slave (
        input  cmd, addr, in_valid, pc, mcu_busy,
        output pause, resume, reset, rf_rd, rf_wr, mem_rd, mem_wr, mem_be,
               out_valid, ctrlr_busy, paused, bp_full, bp_hit
    );
endinterface

// File: rtl/dbg_controller.sv
// ---------------------------------------------------------------------------
// dbg_controller -- on-chip debug controller. Accepts commands from a serial
// decoder, turns them into MCU pause/resume/reset/register/memory requests
// with a busy handshake, and manages a small table of PC breakpoints.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   dbg_if.slave: command in, MCU handshake, requests and status out
//
// Requests are combinational from the state: in the accept cycle they are
// decoded from the live cmd/addr, in the WAIT_ states from the registered
// copies and qualified by mcu_busy.
// ---------------------------------------------------------------------------
module dbg_controller #(
    parameter int NUM_BREAK_PTS = 8,
    parameter int ADDR_W        = 32
) (
    input  logic   clk,
    input  logic   rst,
    dbg_if.slave   bus
);
    localparam logic [3:0] CMD_NONE        = 4'h0;
    localparam logic [3:0] CMD_PAUSE       = 4'h1;
    localparam logic [3:0] CMD_RESUME      = 4'h2;
    localparam logic [3:0] CMD_STEP        = 4'h3;
    localparam logic [3:0] CMD_RESET       = 4'h4;
    localparam logic [3:0] CMD_STATUS      = 4'h5;
    localparam logic [3:0] CMD_MEM_RD_BYTE = 4'h6;
    localparam logic [3:0] CMD_MEM_RD_WORD = 4'h7;
    localparam logic [3:0] CMD_REG_RD      = 4'h8;
    localparam logic [3:0] CMD_BP_ADD      = 4'h9;
    localparam logic [3:0] CMD_BP_RM       = 4'hA;
    localparam logic [3:0] CMD_MEM_WR_BYTE = 4'hB;
    localparam logic [3:0] CMD_MEM_WR_WORD = 4'hC;
    localparam logic [3:0] CMD_REG_WR      = 4'hD;
    localparam logic [3:0] CMD_MEM_RD_HALF = 4'hE;
    localparam logic [3:0] CMD_MEM_WR_HALF = 4'hF;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_WAIT_PAUSE  = 4'd1;
    localparam logic [3:0] ST_WAIT_RESUME = 4'd2;
    localparam logic [3:0] ST_WAIT_STEP   = 4'd3;
    localparam logic [3:0] ST_WAIT_RESET  = 4'd4;
    localparam logic [3:0] ST_WAIT_MEM_RD = 4'd5;
    localparam logic [3:0] ST_WAIT_MEM_WR = 4'd6;
    localparam logic [3:0] ST_WAIT_REG_RD = 4'd7;
    localparam logic [3:0] ST_WAIT_REG_WR = 4'd8;
    localparam logic [3:0] ST_BREAK_HIT   = 4'd9;

    localparam logic [NUM_BREAK_PTS-1:0] BP_ONE = NUM_BREAK_PTS'(1);

    logic [3:0]               state, state_nxt;
    logic [3:0]               cmd_q;
    logic [1:0]               a_q;
    logic                     paused_q;
    logic [ADDR_W-1:0]        bp_addr [NUM_BREAK_PTS];
    logic [NUM_BREAK_PTS-1:0] bp_valid, bp_valid_nxt;
    logic [NUM_BREAK_PTS-1:0] addr_match, pc_match, free_oh;
    logic                     bp_full_q;
    logic [ADDR_W-1:0]        last_hit_pc;
    logic                     last_hit_vld;

    logic                     accept, bp_take, add_en, rm_en;
    logic [3:0]               be_cmd;
    logic [1:0]               be_a;

    // Byte-enable pattern for a memory command at a given address offset.
    function automatic logic [3:0] be_of(input logic [3:0] c, input logic [1:0] a);
        case (c)
            CMD_MEM_RD_BYTE, CMD_MEM_WR_BYTE: be_of = 4'b0001 << a;
            CMD_MEM_RD_HALF, CMD_MEM_WR_HALF: be_of = a[1] ? 4'b1100 : 4'b0011;
            CMD_MEM_RD_WORD, CMD_MEM_WR_WORD: be_of = 4'b1111;
            default:                          be_of = 4'b0000;
        endcase
    endfunction

    // rst gates acceptance so every request output drops the moment rst rises,
    // even if in_valid is still high.
    assign accept = (state == ST_IDLE) && bus.in_valid && !rst;

    always_comb begin
        for (int i = 0; i < NUM_BREAK_PTS; i++) begin
            addr_match[i] = bp_valid[i] && (bp_addr[i] == bus.addr);
            pc_match[i]   = bp_valid[i] && (bp_addr[i] == bus.pc);
        end
    end

    // Lowest clear bit of the valid vector, one-hot.
    assign free_oh = ~bp_valid & (bp_valid + BP_ONE);

    // A breakpoint already taken at this pc stays suppressed until pc moves.
    assign bp_take = (state == ST_IDLE) && !paused_q && !bus.in_valid && !rst &&
                     (|pc_match) && !(last_hit_vld && (last_hit_pc == bus.pc));

    assign add_en = accept && (bus.cmd == CMD_BP_ADD) && !bp_full_q && !(|addr_match);
    assign rm_en  = accept && (bus.cmd == CMD_BP_RM);

    always_comb begin
        bp_valid_nxt = bp_valid;
        if (add_en) bp_valid_nxt = bp_valid_nxt | free_oh;
        if (rm_en)  bp_valid_nxt = bp_valid_nxt & ~addr_match;
    end

    // Accept cycle uses the live command; WAIT_ states use the registered copy.
    assign be_cmd = (state == ST_IDLE) ? bus.cmd        : cmd_q;
    assign be_a   = (state == ST_IDLE) ? bus.addr[1:0]  : a_q;

    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt      = state;
        bus.pause      = 1'b0;
        bus.resume     = 1'b0;
        bus.reset      = 1'b0;
        bus.rf_rd      = 1'b0;
        bus.rf_wr      = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.out_valid  = 1'b0;
        bus.ctrlr_busy = 1'b1;
        case (state)
            ST_IDLE: begin
                bus.ctrlr_busy = 1'b0;
                if (accept) begin
                    case (bus.cmd)
                        CMD_PAUSE: begin
                            bus.pause = 1'b1;
                            state_nxt = ST_WAIT_PAUSE;
                        end
                        CMD_RESUME: begin
                            bus.resume = 1'b1;
                            state_nxt  = ST_WAIT_RESUME;
                        end
                        CMD_STEP: begin
                            if (paused_q) begin
                                bus.resume = 1'b1;
                                state_nxt  = ST_WAIT_STEP;
                            end
                        end
                        CMD_RESET: begin
                            bus.reset = 1'b1;
                            state_nxt = ST_WAIT_RESET;
                        end
                        CMD_MEM_RD_BYTE, CMD_MEM_RD_HALF, CMD_MEM_RD_WORD: begin
                            bus.mem_rd = 1'b1;
                            state_nxt  = ST_WAIT_MEM_RD;
                        end
                        CMD_MEM_WR_BYTE, CMD_MEM_WR_HALF, CMD_MEM_WR_WORD: begin
                            bus.mem_wr = 1'b1;
                            state_nxt  = ST_WAIT_MEM_WR;
                        end
                        CMD_REG_RD: begin
                            bus.rf_rd = 1'b1;
                            state_nxt = ST_WAIT_REG_RD;
                        end
                        CMD_REG_WR: begin
                            bus.rf_wr = 1'b1;
                            state_nxt = ST_WAIT_REG_WR;
                        end
                        default: ;  // NONE, STATUS, BP_ADD, BP_RM finish here
                    endcase
                    // Any command that leaves IDLE is multi-cycle.
                    bus.out_valid  = (state_nxt != ST_IDLE);
                    bus.ctrlr_busy = (state_nxt != ST_IDLE);
                end else if (bp_take) begin
                    state_nxt = ST_BREAK_HIT;
                end
            end
            ST_WAIT_PAUSE: begin
                bus.pause = bus.mcu_busy;
                if (!bus.mcu_busy) state_nxt = ST_IDLE;
            end
            ST_WAIT_RESUME: begin
                bus.resume = bus.mcu_busy;
                if (!bus.mcu_busy) state_nxt = ST_IDLE;
            end
            ST_WAIT_RESET: begin
                bus.reset = bus.mcu_busy;
                if (!bus.mcu_busy) state_nxt = ST_IDLE;
            end
            ST_WAIT_MEM_RD: begin
                bus.mem_rd = bus.mcu_busy;
                if (!bus.mcu_busy) state_nxt = ST_IDLE;
            end
            ST_WAIT_MEM_WR: begin
                bus.mem_wr = bus.mcu_busy;
                if (!bus.mcu_busy) state_nxt = ST_IDLE;
            end
            ST_WAIT_REG_RD: begin
                bus.rf_rd = bus.mcu_busy;
                if (!bus.mcu_busy) state_nxt = ST_IDLE;
            end
            ST_WAIT_REG_WR: begin
                bus.rf_wr = bus.mcu_busy;
                if (!bus.mcu_busy) state_nxt = ST_IDLE;
            end
            ST_WAIT_STEP: begin
                // Single-step: keep resume while the MCU runs, then re-pause.
                bus.out_valid = 1'b1;
                if (bus.mcu_busy) begin
                    bus.resume = 1'b1;
                end else begin
                    bus.pause = 1'b1;
                    state_nxt = ST_WAIT_PAUSE;
                end
            end
            ST_BREAK_HIT: begin
                bus.pause     = 1'b1;
                bus.out_valid = 1'b1;
                state_nxt     = ST_WAIT_PAUSE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.mem_be  = (bus.mem_rd || bus.mem_wr) ? be_of(be_cmd, be_a) : 4'b0000;
    assign bus.paused  = paused_q;
    assign bus.bp_full = bp_full_q;
    assign bus.bp_hit  = (state == ST_BREAK_HIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cmd_q        <= CMD_NONE;
            a_q          <= 2'b00;
            paused_q     <= 1'b0;
            bp_valid     <= '0;
            bp_full_q    <= 1'b0;
            last_hit_pc  <= '0;
            last_hit_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q <= bus.cmd;
                a_q   <= bus.addr[1:0];
            end
            if (!bus.mcu_busy) begin
                if (state == ST_WAIT_PAUSE)
                    paused_q <= 1'b1;
                else if (state == ST_WAIT_RESUME || state == ST_WAIT_RESET)
                    paused_q <= 1'b0;
            end
            bp_valid  <= bp_valid_nxt;
            bp_full_q <= &bp_valid_nxt;
            if (bp_take) begin
                last_hit_pc  <= bus.pc;
                last_hit_vld <= 1'b1;
            end else if (last_hit_vld && (bus.pc != last_hit_pc)) begin
                last_hit_vld <= 1'b0;
            end
        end
    end

    // NOTE: breakpoint addresses are plain storage without reset; only the
    // valid bits are cleared, which is enough to make every slot inert.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BREAK_PTS; i++) begin
            if (add_en && free_oh[i]) bp_addr[i] <= bus.addr;
        end
    end

endmodule

// File: tb/tb_dbg_controller.sv
// ---------------------------------------------------------------------------
// tb_dbg_controller -- self-checking bench for dbg_controller.
// Request cycles are predicted into a queue when stimulus is driven and a
// monitor pops and compares them whenever the DUT shows a request.
// ---------------------------------------------------------------------------
module tb_dbg_controller;
    localparam int ADDR_W = 32;

    localparam logic [3:0] C_NONE = 4'h0, C_PAUSE = 4'h1, C_RESUME = 4'h2, C_STEP = 4'h3;
    localparam logic [3:0] C_RESET = 4'h4, C_STATUS = 4'h5, C_MRB = 4'h6, C_MRW = 4'h7;
    localparam logic [3:0] C_RRD = 4'h8, C_BPADD = 4'h9, C_BPRM = 4'hA, C_MWB = 4'hB;
    localparam logic [3:0] C_MWW = 4'hC, C_RWR = 4'hD, C_MRH = 4'hE, C_MWH = 4'hF;

    // {pause, resume, reset, rf_rd, rf_wr, mem_rd, mem_wr}
    localparam logic [6:0] R_NONE = 7'b0000000, R_PAUSE = 7'b1000000, R_RESUME = 7'b0100000;
    localparam logic [6:0] R_RESET = 7'b0010000, R_RFRD = 7'b0001000, R_RFWR = 7'b0000100;
    localparam logic [6:0] R_MRD = 7'b0000010, R_MWR = 7'b0000001;

    localparam logic [ADDR_W-1:0] PC_FAR = 32'hFFFF_F000;

    typedef struct {
        logic [3:0]        cmd;
        logic [ADDR_W-1:0] addr;
        int                nbusy;
        logic [6:0]        req;
        logic [3:0]        be;
        logic              paused;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [11:0] exp_q [$];

    dbg_if #(.ADDR_W(ADDR_W)) bus ();

    dbg_controller #(.NUM_BREAK_PTS(8), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: any request/qualifier activity must match the next predicted cycle.
    always @(negedge clk) begin
        logic [11:0] act;
        logic [11:0] e;
        #2;
        act = {bus.pause, bus.resume, bus.reset, bus.rf_rd, bus.rf_wr,
               bus.mem_rd, bus.mem_wr, bus.mem_be, bus.out_valid};
        if (act != 12'h0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", act, 12'h0);
            end else begin
                e = exp_q.pop_front();
                check("sb_req", act, e);
            end
        end
    end

    // One command: accept cycle, nbusy busy cycles, exit cycle, back in IDLE.
    task automatic run_cmd(input logic [3:0] c, input logic [ADDR_W-1:0] a, input int nbusy,
                           input logic [6:0] req, input logic [3:0] be);
        @(negedge clk);
        bus.cmd = c; bus.addr = a; bus.in_valid = 1'b1; bus.mcu_busy = 1'b0;
        if (req != R_NONE) exp_q.push_back({req, be, 1'b1});
        #1 check("busy_accept", bus.ctrlr_busy, (req != R_NONE));
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (req != R_NONE) begin
            for (int k = 0; k < nbusy; k++) begin
                bus.mcu_busy = 1'b1;
                exp_q.push_back({req, be, 1'b0});
                @(negedge clk);
            end
            bus.mcu_busy = 1'b0;
            #1 check("busy_exit", bus.ctrlr_busy, 1'b1);
            @(negedge clk);
        end
        #1 check("idle_after", bus.ctrlr_busy, 1'b0);
        check("sb_drain", exp_q.size(), 0);
    endtask

    // Single-cycle breakpoint table command.
    task automatic bp_cmd(input logic [3:0] c, input logic [ADDR_W-1:0] a);
        @(negedge clk);
        bus.cmd = c; bus.addr = a; bus.in_valid = 1'b1;
        #1 check("bp_cmd_busy", bus.ctrlr_busy, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
    endtask

    // Called right after the negedge that starts the BREAK_HIT cycle.
    task automatic expect_break();
        exp_q.push_back({R_PAUSE, 4'h0, 1'b1});
        #1 check("bp_hit_pulse", bus.bp_hit, 1'b1);
        check("bp_busy", bus.ctrlr_busy, 1'b1);
        @(negedge clk);
        bus.mcu_busy = 1'b1;
        exp_q.push_back({R_PAUSE, 4'h0, 1'b0});
        #1 check("bp_hit_one_cycle", bus.bp_hit, 1'b0);
        @(negedge clk);
        bus.mcu_busy = 1'b0;
        @(negedge clk);
        #1 check("bp_paused", bus.paused, 1'b1);
        check("bp_idle", bus.ctrlr_busy, 1'b0);
        check("bp_sb_drain", exp_q.size(), 0);
    endtask

    vec_t vecs [16];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vecs[0]  = '{C_PAUSE,  32'h0,   3, R_PAUSE,  4'b0000, 1'b1};
        vecs[1]  = '{C_MRB,    32'h101, 1, R_MRD,    4'b0010, 1'b1};
        vecs[2]  = '{C_MRB,    32'h103, 2, R_MRD,    4'b1000, 1'b1};
        vecs[3]  = '{C_MRW,    32'h200, 1, R_MRD,    4'b1111, 1'b1};
        vecs[4]  = '{C_MRH,    32'h000, 1, R_MRD,    4'b0011, 1'b1};
        vecs[5]  = '{C_MWH,    32'h102, 2, R_MWR,    4'b1100, 1'b1};
        vecs[6]  = '{C_MWB,    32'h100, 0, R_MWR,    4'b0001, 1'b1};
        vecs[7]  = '{C_MWW,    32'h003, 1, R_MWR,    4'b1111, 1'b1};
        vecs[8]  = '{C_RRD,    32'h5,   1, R_RFRD,   4'b0000, 1'b1};
        vecs[9]  = '{C_RWR,    32'h7,   2, R_RFWR,   4'b0000, 1'b1};
        vecs[10] = '{C_STATUS, 32'h0,   0, R_NONE,   4'b0000, 1'b1};
        vecs[11] = '{C_RESUME, 32'h0,   2, R_RESUME, 4'b0000, 1'b0};
        vecs[12] = '{C_RESET,  32'h0,   1, R_RESET,  4'b0000, 1'b0};
        vecs[13] = '{C_NONE,   32'h0,   0, R_NONE,   4'b0000, 1'b0};
        vecs[14] = '{C_PAUSE,  32'h0,   0, R_PAUSE,  4'b0000, 1'b1};
        vecs[15] = '{C_RESET,  32'h0,   0, R_RESET,  4'b0000, 1'b0};

        // Reset state, with a command presented during reset.
        rst = 1'b1;
        bus.cmd = C_PAUSE; bus.addr = '0; bus.in_valid = 1'b1;
        bus.pc = PC_FAR; bus.mcu_busy = 1'b0;
        #1;
        check("rst_pause", bus.pause, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.ctrlr_busy, 1'b0);
        check("rst_paused", bus.paused, 1'b0);
        check("rst_bp_full", bus.bp_full, 1'b0);
        check("rst_bp_hit", bus.bp_hit, 1'b0);
        check("rst_mem_be", bus.mem_be, 4'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // Command table.
        foreach (vecs[i]) begin
            run_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].nbusy, vecs[i].req, vecs[i].be);
            check($sformatf("paused_after_%0d", i), bus.paused, vecs[i].paused);
        end

        // STEP while running: no-op.
        @(negedge clk);
        bus.cmd = C_STEP; bus.in_valid = 1'b1;
        #1 check("step_run_busy", bus.ctrlr_busy, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 check("step_run_idle", bus.ctrlr_busy, 1'b0);
        check("step_run_paused", bus.paused, 1'b0);

        // STEP while paused: resume during busy, then pause.
        run_cmd(C_PAUSE, 32'h0, 1, R_PAUSE, 4'h0);
        @(negedge clk);
        bus.cmd = C_STEP; bus.in_valid = 1'b1;
        exp_q.push_back({R_RESUME, 4'h0, 1'b1});
        #1 check("step_busy", bus.ctrlr_busy, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mcu_busy = 1'b1;
        exp_q.push_back({R_RESUME, 4'h0, 1'b1});
        @(negedge clk);
        bus.mcu_busy = 1'b0;
        exp_q.push_back({R_PAUSE, 4'h0, 1'b1});
        @(negedge clk);
        @(negedge clk);
        #1 check("step_paused", bus.paused, 1'b1);
        check("step_idle", bus.ctrlr_busy, 1'b0);
        check("step_sb_drain", exp_q.size(), 0);
        run_cmd(C_RESUME, 32'h0, 1, R_RESUME, 4'h0);

        // Fill the breakpoint table.
        for (int i = 0; i < 8; i++) begin
            bp_cmd(C_BPADD, ADDR_W'(i * 4));
            if (i == 6) check("bp_not_full_7", bus.bp_full, 1'b0);
        end
        check("bp_full_8", bus.bp_full, 1'b1);
        bp_cmd(C_BPADD, 32'h40);            // ninth add: ignored
        @(negedge clk);
        bus.pc = 32'h40;
        repeat (2) begin
            @(negedge clk);
            #1 check("bp_ninth_ignored", bus.bp_hit, 1'b0);
        end
        bus.pc = PC_FAR;
        bp_cmd(C_BPRM, 32'h8);
        check("bp_rm_not_full", bus.bp_full, 1'b0);
        bp_cmd(C_BPADD, 32'h40);
        check("bp_refill_full", bus.bp_full, 1'b1);
        check("bp_slot2_addr", dut.bp_addr[2], 32'h40);
        bp_cmd(C_BPRM, 32'h0);
        check("bp_rm0_not_full", bus.bp_full, 1'b0);
        bp_cmd(C_BPADD, 32'h4);             // duplicate: ignored
        check("bp_dup_ignored", bus.bp_full, 1'b0);
        bp_cmd(C_BPADD, 32'h20);
        check("bp_add20_full", bus.bp_full, 1'b1);

        // Breakpoint taken at 0x20.
        @(negedge clk);
        bus.pc = 32'h20;
        #1 check("bp_take_cycle", bus.bp_hit, 1'b0);
        @(negedge clk);
        expect_break();

        // RESUME with pc held: no re-hit.
        run_cmd(C_RESUME, 32'h0, 1, R_RESUME, 4'h0);
        check("resume_paused", bus.paused, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1 check("no_rehit", bus.bp_hit, 1'b0);
            check("no_rehit_busy", bus.ctrlr_busy, 1'b0);
        end

        // pc moves away and back: taken again.
        @(negedge clk);
        bus.pc = 32'h100;
        @(negedge clk);
        bus.pc = 32'h20;
        @(negedge clk);
        expect_break();
        bus.pc = 32'h100;
        run_cmd(C_RESUME, 32'h0, 1, R_RESUME, 4'h0);

        // Command and breakpoint in the same IDLE cycle: command first.
        @(negedge clk);
        bus.pc = 32'h10; bus.cmd = C_STATUS; bus.in_valid = 1'b1;
        #1 check("cmd_wins_busy", bus.ctrlr_busy, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 check("cmd_wins_no_hit", bus.bp_hit, 1'b0);
        check("cmd_wins_idle", bus.ctrlr_busy, 1'b0);
        @(negedge clk);
        expect_break();
        bus.pc = PC_FAR;

        // Reset in the middle of a memory read.
        @(negedge clk);
        bus.cmd = C_MRW; bus.addr = 32'h0; bus.in_valid = 1'b1;
        exp_q.push_back({R_MRD, 4'b1111, 1'b1});
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mcu_busy = 1'b1;
        exp_q.push_back({R_MRD, 4'b1111, 1'b0});
        #3 rst = 1'b1;
        #1;
        check("rst_mid_mem_rd", bus.mem_rd, 1'b0);
        check("rst_mid_be", bus.mem_be, 4'h0);
        check("rst_mid_busy", bus.ctrlr_busy, 1'b0);
        check("rst_mid_bp_full", bus.bp_full, 1'b0);
        check("rst_mid_paused", bus.paused, 1'b0);
        @(negedge clk);
        rst = 1'b0; bus.mcu_busy = 1'b0;
        @(negedge clk);
        #1 check("post_rst_idle", bus.ctrlr_busy, 1'b0);
        check("post_rst_bp_full", bus.bp_full, 1'b0);

        check("sb_final", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dbg_controller.md
DBG_CONTROLLER -- requirements
Module: dbg_controller

Interface
REQ-001 SHALL have parameter NUM_BREAK_PTS, default 8, giving the number of breakpoint slots (1..32).
REQ-002 SHALL have parameter ADDR_W, default 32, giving the width of the address and the PC.
REQ-003 SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd  in  4  command code from the serial decoder.
- addr  in  ADDR_W  command address or breakpoint address.
- in_valid  in  1  command strobe.
- pc  in  ADDR_W  current MCU program counter.
- mcu_busy  in  1  MCU acknowledge and busy.
- pause, resume, reset, rf_rd, rf_wr, mem_rd, mem_wr  out  1 each  MCU requests.
- mem_be  out  4  byte enables.
- out_valid  out  1  request qualifier.
- ctrlr_busy  out  1  controller cannot accept a command.
- paused  out  1  MCU-paused flag.
- bp_full  out  1  all breakpoint slots are valid.
- bp_hit  out  1  one-cycle pulse when a breakpoint is taken.

Function
REQ-004 SHALL decode these commands: 0 NONE, 1 PAUSE, 2 RESUME, 3 STEP, 4 RESET, 5 STATUS, 6 MEM_RD_BYTE, 7 MEM_RD_WORD, 8 REG_RD, 9 BP_ADD, A BP_RM, B MEM_WR_BYTE, C MEM_WR_WORD, D REG_WR, E MEM_RD_HALF, F MEM_WR_HALF.
REQ-005 SHALL use these states: IDLE, WAIT_PAUSE, WAIT_RESUME, WAIT_STEP, WAIT_RESET, WAIT_MEM_RD, WAIT_MEM_WR, WAIT_REG_RD, WAIT_REG_WR, BREAK_HIT.
REQ-006 SHALL accept a command only in IDLE with in_valid=1, and SHALL register cmd and addr[1:0] on acceptance; all later request outputs for that command use the registered values.
REQ-007 SHALL drive ctrlr_busy=0 only in IDLE when no multi-cycle command is accepted that cycle; it is 1 in every other state.
REQ-008 For PAUSE, RESUME, RESET, MEM_*, REG_RD and REG_WR, SHALL assert the matching request and out_valid in the accept cycle, enter the matching WAIT_ state, hold the request while mcu_busy=1, and return to IDLE in the first cycle with mcu_busy=0.
REQ-009 SHALL assert out_valid only in the accept cycle, in WAIT_STEP, and in BREAK_HIT.
REQ-010 mem_be SHALL be:
- byte commands: 1<<addr[1:0].
- half commands: 4'b0011 if addr[1]=0, else 4'b1100.
- word commands: 4'b1111.
- otherwise: 0.
REQ-011 SHALL set paused on exit from WAIT_PAUSE and clear it on exit from WAIT_RESUME or WAIT_RESET.
REQ-012 STEP with paused=1 SHALL:
- assert resume+out_valid and enter WAIT_STEP;
- in WAIT_STEP, hold resume while mcu_busy=1;
- then assert pause and enter WAIT_PAUSE.
REQ-013 STEP with paused=0 SHALL be a no-op: stay in IDLE, ctrlr_busy=0.
REQ-014 STATUS and NONE SHALL complete in the accept cycle with no request asserted.
REQ-015 Each breakpoint slot SHALL hold an ADDR_W address and a valid bit.
REQ-016 BP_ADD SHALL write addr into the lowest-index invalid slot and set its valid bit. It SHALL be ignored when bp_full=1 or when addr already matches a valid slot. It completes in one cycle.
REQ-017 BP_RM SHALL clear the valid bit of every slot matching addr, and SHALL be ignored if no slot matches. It completes in one cycle.
REQ-018 bp_full SHALL be the AND of all valid bits, registered from the slot state.
REQ-019 A breakpoint SHALL be taken only when all of these hold: state is IDLE, paused=0, in_valid=0, and pc equals the address of some valid slot.
REQ-020 When a breakpoint is taken, the next state SHALL be BREAK_HIT and bp_hit SHALL pulse for one cycle.
REQ-021 When in_valid=1 and a breakpoint match occur in the same IDLE cycle, the command SHALL win and the breakpoint is re-evaluated on the next IDLE cycle.
REQ-022 BREAK_HIT SHALL assert pause+out_valid for one cycle, then go to WAIT_PAUSE.
REQ-023 A breakpoint SHALL NOT be re-taken at the same pc after a RESUME until pc changes; this needs a registered last-hit PC and a last-hit valid flag, which are cleared when pc differs.
REQ-024 Undefined states SHALL return to IDLE.

Reset
REQ-025 rst=1 SHALL immediately force:
- state IDLE;
- paused=0;
- all valid bits 0, bp_full=0;
- last-hit flag 0;
- all request outputs, out_valid and bp_hit 0, mem_be=0;
- ctrlr_busy=0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation with no completion cycle, and breakpoint addresses need not be cleared.

Verification
REQ-027 PAUSE with mcu_busy high for 3 cycles -> pause high for 4 cycles, paused=1 on return to IDLE, ctrlr_busy low after 5 cycles.
REQ-028 MEM_WR_HALF addr=0x102, mcu_busy 2 cycles -> mem_wr=1, mem_be=4'b1100 held every busy cycle, then IDLE.
REQ-029 Add 8 breakpoints 0x0..0x1C with NUM_BREAK_PTS=8 -> bp_full=1; a 9th add is ignored; BP_RM 0x8 -> bp_full=0; next add of 0x40 lands in slot 2.
REQ-030 Running with a breakpoint at 0x20 and pc=0x20 -> bp_hit pulse, BREAK_HIT, then pause, paused=1. RESUME with pc held at 0x20 -> no re-hit.
REQ-031 STEP while paused -> resume, then pause, paused=1 at end. STEP while running -> no request, ctrlr_busy stays 0.
REQ-032 rst pulsed during WAIT_MEM_RD -> mem_rd drops the same cycle, state IDLE, bp_full=0, paused=0.
